// File: rtl/mdio_link_manager.sv
// mdio_link_manager: sequencer and arbiter in front of a clause-22 MDIO master
// engine. After reset it writes the PHY control register once, then polls the
// basic status register (and, when the link is up, the PHY-specific status
// register) every POLL_INTERVAL cycles, publishing link_up/speed/full_duplex to
// the MAC. Host register accesses share the engine, one transaction at a time.
// Optional feature macro: MDIO_LINK_IRQ_EN adds the link_change pulse output.
module mdio_link_manager #(
  parameter logic [4:0]  PHY_ADDR      = 5'd1,
  parameter int          POLL_INTERVAL = 1250000,
  parameter logic [15:0] INIT_BMCR     = 16'h1140,
  parameter logic [4:0]  STAT_REG      = 5'd17
) (
  input  logic        clk,
  input  logic        reset,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        cmd_write,
  output logic [4:0]  cmd_phyaddr,
  output logic [4:0]  cmd_regaddr,
  output logic [15:0] cmd_wdata,
  input  logic        rsp_valid,
  input  logic [15:0] rsp_rdata,
  input  logic        host_valid,
  output logic        host_ready,
  input  logic        host_write,
  input  logic [4:0]  host_regaddr,
  input  logic [15:0] host_wdata,
  output logic        host_rsp_valid,
  output logic [15:0] host_rdata,
  output logic        link_up,
  output logic [1:0]  speed,
  output logic        full_duplex,
  output logic        status_valid,
  output logic        busy
`ifdef MDIO_LINK_IRQ_EN
  ,
  output logic        link_change
`endif
);

  typedef enum logic [3:0] {
    S_INIT_WR, S_INIT_WAIT, S_IDLE,
    S_POLL_BMSR, S_BMSR_WAIT, S_POLL_STAT, S_STAT_WAIT,
    S_HOST_CMD, S_HOST_WAIT
  } state_t;

  localparam logic [4:0] BMCR_REG = 5'd0;
  localparam logic [4:0] BMSR_REG = 5'd1;
  localparam int         TW         = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(POLL_INTERVAL - 1);

  state_t        state, state_nxt;
  logic [TW-1:0] poll_timer;
  logic          timer_run;
  logic          poll_pending;
  logic          host_write_q;
  logic [4:0]    host_regaddr_q;
  logic [15:0]   host_wdata_q;

  logic          init_done;
  logic          enter_poll;
  logic          host_done;
  logic          status_upd;
  logic          link_nxt;
  logic [1:0]    speed_nxt;
  logic          duplex_nxt;

  // Next-state, engine request fields and status decode for the sequencer.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path through
    // the case statement can leave a value unassigned and infer a latch.
    state_nxt   = state;
    cmd_valid   = 1'b0;
    cmd_write   = 1'b0;
    cmd_phyaddr = 5'd0;
    cmd_regaddr = 5'd0;
    cmd_wdata   = 16'd0;
    host_ready  = 1'b0;
    init_done   = 1'b0;
    enter_poll  = 1'b0;
    host_done   = 1'b0;
    status_upd  = 1'b0;
    link_nxt    = link_up;
    speed_nxt   = speed;
    duplex_nxt  = full_duplex;

    case (state)
      S_INIT_WR: begin
        cmd_valid   = 1'b1;
        cmd_write   = 1'b1;
        cmd_phyaddr = PHY_ADDR;
        cmd_regaddr = BMCR_REG;
        cmd_wdata   = INIT_BMCR;
        if (cmd_ready) state_nxt = S_INIT_WAIT;
      end
      S_INIT_WAIT: begin
        if (rsp_valid) begin
          state_nxt = S_IDLE;
          init_done = 1'b1;
        end
      end
      S_IDLE: begin
        // A due poll always beats the host; the host is accepted here.
        if (poll_pending) begin
          state_nxt  = S_POLL_BMSR;
          enter_poll = 1'b1;
        end else if (host_valid) begin
          state_nxt  = S_HOST_CMD;
          host_ready = 1'b1;
        end
      end
      S_POLL_BMSR: begin
        cmd_valid   = 1'b1;
        cmd_phyaddr = PHY_ADDR;
        cmd_regaddr = BMSR_REG;
        if (cmd_ready) state_nxt = S_BMSR_WAIT;
      end
      S_BMSR_WAIT: begin
        if (rsp_valid) begin
          if (rsp_rdata[2]) begin
            state_nxt = S_POLL_STAT;
          end else begin
            // Link down: speed/duplex keep their last known values.
            state_nxt  = S_IDLE;
            status_upd = 1'b1;
            link_nxt   = 1'b0;
          end
        end
      end
      S_POLL_STAT: begin
        cmd_valid   = 1'b1;
        cmd_phyaddr = PHY_ADDR;
        cmd_regaddr = STAT_REG;
        if (cmd_ready) state_nxt = S_STAT_WAIT;
      end
      S_STAT_WAIT: begin
        if (rsp_valid) begin
          state_nxt  = S_IDLE;
          status_upd = 1'b1;
          if (rsp_rdata[15:14] == 2'b11) begin
            // Reserved speed code: report link down, hold speed/duplex.
            link_nxt = 1'b0;
          end else begin
            link_nxt   = 1'b1;
            speed_nxt  = rsp_rdata[15:14];
            duplex_nxt = rsp_rdata[13];
          end
        end
      end
      S_HOST_CMD: begin
        cmd_valid   = 1'b1;
        cmd_write   = host_write_q;
        cmd_phyaddr = PHY_ADDR;
        cmd_regaddr = host_regaddr_q;
        cmd_wdata   = host_write_q ? host_wdata_q : 16'd0;
        if (cmd_ready) state_nxt = S_HOST_WAIT;
      end
      S_HOST_WAIT: begin
        if (rsp_valid) begin
          state_nxt = S_IDLE;
          host_done = 1'b1;
        end
      end
      default: state_nxt = S_INIT_WR;
    endcase

    // NOTE: the state register only resets at the clock edge, so the
    // combinational request/handshake outputs are forced low while reset is
    // held; otherwise they would show the pre-reset state for a cycle.
    if (reset) begin
      cmd_valid   = 1'b0;
      cmd_write   = 1'b0;
      cmd_phyaddr = 5'd0;
      cmd_regaddr = 5'd0;
      cmd_wdata   = 16'd0;
      host_ready  = 1'b0;
    end
  end

  assign busy = (state != S_IDLE) && !reset;

  // Sequencer state register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (reset) state <= S_INIT_WR;
    else       state <= state_nxt;
  end

  // Free-running poll timer (enabled once init completes) and the
  // single-entry poll request flag; expiries while pending are absorbed.
  always_ff @(posedge clk) begin
    if (reset) begin
      poll_timer   <= '0;
      timer_run    <= 1'b0;
      poll_pending <= 1'b0;
    end else begin
      if (init_done) timer_run <= 1'b1;
      if (timer_run) begin
        poll_timer <= (poll_timer == TIMER_LAST) ? '0 : poll_timer + TW'(1);
      end
      if (timer_run && (poll_timer == TIMER_LAST)) poll_pending <= 1'b1;
      else if (enter_poll)                         poll_pending <= 1'b0;
    end
  end

  // Link status outputs, all updated together on a completed poll.
  always_ff @(posedge clk) begin
    if (reset) begin
      link_up      <= 1'b0;
      speed        <= 2'b00;
      full_duplex  <= 1'b0;
      status_valid <= 1'b0;
    end else if (status_upd) begin
      link_up      <= link_nxt;
      speed        <= speed_nxt;
      full_duplex  <= duplex_nxt;
      status_valid <= 1'b1;
    end
  end

`ifdef MDIO_LINK_IRQ_EN
  // Change pulse on a status update that alters any published field.
  always_ff @(posedge clk) begin
    if (reset) link_change <= 1'b0;
    else       link_change <= status_upd &&
                              ({link_nxt, speed_nxt, duplex_nxt} != {link_up, speed, full_duplex});
  end
`endif

  // Host request capture and host response.
  always_ff @(posedge clk) begin
    if (reset) begin
      host_write_q   <= 1'b0;
      host_regaddr_q <= 5'd0;
      host_wdata_q   <= 16'd0;
      host_rsp_valid <= 1'b0;
      host_rdata     <= 16'd0;
    end else begin
      host_rsp_valid <= host_done;
      if (host_ready) begin
        host_write_q   <= host_write;
        host_regaddr_q <= host_regaddr;
        host_wdata_q   <= host_wdata;
      end
      if (host_done) host_rdata <= host_write_q ? 16'd0 : rsp_rdata;
    end
  end

endmodule

// File: tb/tb_mdio_link_manager.sv
// tb_mdio_link_manager: directed bench for mdio_link_manager with a small
// MDIO engine/PHY responder. Compile with MDIO_LINK_IRQ_EN to also cover
// the link_change pulse.
module tb_mdio_link_manager;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [4:0]  cmd_phyaddr, cmd_regaddr;
  logic [15:0] cmd_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        host_valid, host_ready, host_write;
  logic [4:0]  host_regaddr;
  logic [15:0] host_wdata;
  logic        host_rsp_valid;
  logic [15:0] host_rdata;
  logic        link_up, full_duplex, status_valid, busy;
  logic [1:0]  speed;
`ifdef MDIO_LINK_IRQ_EN
  logic        link_change;
`endif

  always #4 clk = ~clk;

  mdio_link_manager #(
    .PHY_ADDR(5'd1), .POLL_INTERVAL(16), .INIT_BMCR(16'h1140), .STAT_REG(5'd17)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_phyaddr(cmd_phyaddr), .cmd_regaddr(cmd_regaddr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .host_valid(host_valid), .host_ready(host_ready), .host_write(host_write),
    .host_regaddr(host_regaddr), .host_wdata(host_wdata),
    .host_rsp_valid(host_rsp_valid), .host_rdata(host_rdata),
    .link_up(link_up), .speed(speed), .full_duplex(full_duplex),
    .status_valid(status_valid), .busy(busy)
`ifdef MDIO_LINK_IRQ_EN
    , .link_change(link_change)
`endif
  );

  typedef struct {
    logic [4:0]  ra;
    logic        wr;
    logic [15:0] wd;
    logic [4:0]  pa;
  } txn_t;

  txn_t        log_q[$];
  logic        stall;
  logic [15:0] bmsr_val, stat_val;
  int          n_vec = 0;
  int          n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] phy_reg(input logic [4:0] ra);
    case (ra)
      5'd1:    return bmsr_val;
      5'd17:   return stat_val;
      5'd2:    return 16'h0141;
      default: return 16'hDEAD;
    endcase
  endfunction

  // Engine/PHY model: accept in the first non-stalled cycle, respond two
  // cycles after acceptance with a one-cycle rsp_valid.
  initial begin
    txn_t t;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_rdata = 16'd0;
    forever begin
      @(negedge clk);
      rsp_valid = 1'b0;
      if (cmd_valid && !stall && !reset) begin
        t.ra = cmd_regaddr; t.wr = cmd_write; t.wd = cmd_wdata; t.pa = cmd_phyaddr;
        log_q.push_back(t);
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        @(negedge clk);
        rsp_valid = 1'b1;
        rsp_rdata = t.wr ? 16'd0 : phy_reg(t.ra);
      end
    end
  end

  task automatic wait_idle(input string tag);
    int run = 0;
    for (int i = 0; i < 200 && run < 2; i++) begin
      @(negedge clk);
      run = busy ? 0 : run + 1;
    end
    check(tag, run >= 2, 1'b1);
  endtask

  task automatic wait_link(input logic want, input string tag);
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (link_up == want) break;
    end
    check(tag, link_up, want);
  endtask

  task automatic host_xfer(input logic wr, input logic [4:0] ra, input logic [15:0] wd,
                           output logic [15:0] rd);
    logic seen;
    rd = 16'hxxxx;
    @(posedge clk); #1;
    host_valid = 1'b1; host_write = wr; host_regaddr = ra; host_wdata = wd;
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (host_ready) begin seen = 1'b1; break; end
    end
    check("host_ready_seen", seen, 1'b1);
    @(posedge clk); #1;
    host_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (host_rsp_valid) begin seen = 1'b1; rd = host_rdata; break; end
    end
    check("host_rsp_seen", seen, 1'b1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rd;
    logic        found;
    int          cnt, bad, pulses;
    logic [24:0] order;

    reset = 1'b1; stall = 1'b1;
    host_valid = 1'b0; host_write = 1'b0; host_regaddr = 5'd0; host_wdata = 16'd0;
    bmsr_val = 16'h0004; stat_val = 16'hA000;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_valid", cmd_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_status", {link_up, speed, full_duplex, status_valid}, 5'd0);
    check("rst_host", {host_ready, host_rsp_valid, host_rdata}, 18'd0);
`ifdef MDIO_LINK_IRQ_EN
    check("rst_link_change", link_change, 1'b0);
`endif

    // Init write presented in the first cycle after reset release.
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("init_valid", cmd_valid, 1'b1);
    check("init_fields", {cmd_write, cmd_phyaddr, cmd_regaddr, cmd_wdata},
          {1'b1, 5'd1, 5'd0, 16'h1140});
    check("init_busy", busy, 1'b1);
    @(posedge clk); #1 stall = 1'b0;
    wait_idle("init_idle");
    check("init_no_status", status_valid, 1'b0);

    // First poll: link up, 1000M full duplex.
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (status_valid) break;
    end
    check("poll1_status_valid", status_valid, 1'b1);
    check("poll1_status", {link_up, speed, full_duplex}, {1'b1, 2'b10, 1'b1});

    // BMSR link bit clear: link drops, no STAT read, speed/duplex held.
    wait_idle("down_idle0");
    bmsr_val = 16'h0000;
    log_q.delete();
    wait_link(1'b0, "down_link");
    wait_idle("down_idle1");
    check("down_hold", {speed, full_duplex, status_valid}, {2'b10, 1'b1, 1'b1});
    cnt = 0; bad = 0;
    foreach (log_q[i]) begin
      if (log_q[i].ra == 5'd17) cnt++;
      if (log_q[i].ra == 5'd1)  bad++;
    end
    check("down_no_stat_read", cnt, 0);
    check("down_bmsr_read", bad > 0, 1'b1);

    // 100M half duplex, then reserved speed code.
    bmsr_val = 16'h0004; stat_val = 16'h4000;
    wait_link(1'b1, "m100_link");
    check("m100_status", {speed, full_duplex}, {2'b01, 1'b0});
    wait_idle("rsvd_idle");
    stat_val = 16'hC000;
    wait_link(1'b0, "rsvd_link");
    check("rsvd_hold", {speed, full_duplex, status_valid}, {2'b01, 1'b0, 1'b1});

    // Engine stalled for three poll periods with a host read arriving:
    // stalled poll, one collapsed pending poll, then the host read.
    wait_idle("stall_idle");
    stat_val = 16'hA000;
    @(posedge clk); #1 stall = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (cmd_valid && cmd_regaddr == 5'd1) begin found = 1'b1; break; end
    end
    check("stall_poll_req", found, 1'b1);
    log_q.delete();
    bad = 0;
    fork
      begin
        repeat (45) begin
          @(negedge clk);
          if (!(cmd_valid && !cmd_write && cmd_regaddr == 5'd1 && cmd_phyaddr == 5'd1 &&
                cmd_wdata == 16'd0)) bad++;
        end
        @(posedge clk); #1 stall = 1'b0;
      end
      begin
        repeat (10) @(posedge clk);
        host_xfer(1'b0, 5'd2, 16'd0, rd);
      end
    join
    check("stall_fields_stable", bad, 0);
    check("host_read_data", rd, 16'h0141);
    for (int i = 0; i < 100 && log_q.size() < 5; i++) @(negedge clk);
    order = 25'd0;
    if (log_q.size() >= 5)
      order = {log_q[0].ra, log_q[1].ra, log_q[2].ra, log_q[3].ra, log_q[4].ra};
    check("stall_order", order, {5'd1, 5'd17, 5'd1, 5'd17, 5'd2});
    check("stall_status", {link_up, speed, full_duplex}, {1'b1, 2'b10, 1'b1});

    // Host write: fields forwarded, host_rdata reads back 0.
    wait_idle("hw_idle");
    log_q.delete();
    host_xfer(1'b1, 5'd4, 16'h01E1, rd);
    check("host_write_rdata", rd, 16'd0);
    found = 1'b0;
    foreach (log_q[i])
      if (log_q[i].ra == 5'd4 && log_q[i].wr && log_q[i].wd == 16'h01E1 && log_q[i].pa == 5'd1)
        found = 1'b1;
    check("host_write_fields", found, 1'b1);

    // Reset asserted while the STAT read is outstanding.
    found = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (cmd_valid && cmd_regaddr == 5'd17) begin found = 1'b1; break; end
    end
    check("rst2_stat_req", found, 1'b1);
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst2_status", {link_up, speed, full_duplex, status_valid}, 5'd0);
    check("rst2_cmd", {cmd_valid, busy}, 2'b00);
`ifdef MDIO_LINK_IRQ_EN
    check("rst2_link_change", link_change, 1'b0);
`endif
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("rst2_init_reissue", {cmd_valid, cmd_write, cmd_regaddr, cmd_wdata},
          {1'b1, 1'b1, 5'd0, 16'h1140});
    pulses = 0;
    repeat (120) begin
      @(negedge clk);
`ifdef MDIO_LINK_IRQ_EN
      if (link_change) pulses++;
`endif
    end
    check("rst2_relink", {status_valid, link_up, speed, full_duplex}, {1'b1, 1'b1, 2'b10, 1'b1});
`ifdef MDIO_LINK_IRQ_EN
    check("link_change_once", pulses, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
